// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - round-robin scan sequencer for a 7-input sensor mux
//
// Purpose:
//    Steps through the enabled mux channels 0..5 in round-robin order. For each channel
//    it drives the mux select code, waits SETTLE_CYCLES, captures the mux output and
//    offers it downstream on a valid/ready handshake. Error-mode reads (select 5'b11111,
//    reported as channel 6) pre-empt channel reads.
//
// Ports:
//    clk           in   1       clock, all state changes on the rising edge
//    rst           in   1       synchronous reset, active high
//    enable        in   1       run scanning; low stops after the current sample
//    ch_mask       in   6       bit i set -> channel i is scanned
//    error_req     in   1       level request for an error-mode read
//    mux_select    out  5       select code driven to the mux
//    mux_data      in   DATA_W  mux output
//    sample_data   out  DATA_W  captured sample
//    sample_ch     out  3       channel of the sample (0..5, 6 = error read)
//    sample_valid  out  1       sample available
//    sample_ready  in   1       downstream accepts the sample
//    busy          out  1       sequencer is not idle
//    error_active  out  1       error read in progress or awaiting handshake

module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter int DATA_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [5:0]        ch_mask,
   input  logic              error_req,
   output logic [4:0]        mux_select,
   input  logic [DATA_W-1:0] mux_data,
   output logic [DATA_W-1:0] sample_data,
   output logic [2:0]        sample_ch,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              error_active
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_SETTLE     = 2'd1;
   localparam logic [1:0] ST_HOLD       = 2'd2;
   localparam logic [1:0] ST_ERR_SETTLE = 2'd3;

   // The counter only has to reach SETTLE_CYCLES-1.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [2:0] ERR_CH  = 3'd6;
   localparam logic [4:0] SEL_ERR = 5'b11111;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        ptr_q, ptr_d;
   logic [2:0]        ch_q, ch_d;
   logic [4:0]        sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [2:0]        sch_q, sch_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic [2:0]        pick_ch;
   logic              hit_hi;

   // Channel 0 shares the all-zero select code with the reset value.
   function automatic logic [4:0] sel_code(input logic [2:0] ch);
      case (ch)
         3'd0:    sel_code = 5'b00000;
         3'd1:    sel_code = 5'b00001;
         3'd2:    sel_code = 5'b00010;
         3'd3:    sel_code = 5'b00100;
         3'd4:    sel_code = 5'b01000;
         3'd5:    sel_code = 5'b10000;
         default: sel_code = 5'b00000;
      endcase
   endfunction

   // Lowest enabled channel at or above the pointer; if none, wrap to the lowest
   // enabled channel overall. Descending loops leave the lowest hit as the winner.
   always_comb begin
      pick_ch = 3'd0;
      hit_hi  = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         if (ch_mask[3'(i)] && (3'(i) >= ptr_q)) begin
            pick_ch = 3'(i);
            hit_hi  = 1'b1;
         end
      end
      if (!hit_hi) begin
         for (int i = 5; i >= 0; i--) begin
            if (ch_mask[3'(i)]) begin
               pick_ch = 3'(i);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      ch_d    = ch_q;
      sel_d   = sel_q;
      data_d  = data_q;
      sch_d   = sch_q;
      valid_d = valid_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (error_req) begin
               sel_d   = SEL_ERR;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_ERR_SETTLE;
            end else if (enable && (ch_mask != 6'd0)) begin
               ch_d    = pick_ch;
               sel_d   = sel_code(pick_ch);
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // An error request abandons the channel read; ptr stays put so the
            // same channel is retried after the error sample.
            if (error_req) begin
               sel_d   = SEL_ERR;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_ERR_SETTLE;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = mux_data;
               sch_d   = ch_q;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end

         ST_ERR_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               data_d  = mux_data;
               sch_d   = ERR_CH;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (sample_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               if (sch_q == ERR_CH) begin
                  err_d = 1'b0;
               end else begin
                  ptr_d = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= 3'd0;
         ch_q    <= 3'd0;
         sel_q   <= 5'b00000;
         data_q  <= '0;
         sch_q   <= 3'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         sch_q   <= sch_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign mux_select   = sel_q;
   assign sample_data  = data_q;
   assign sample_ch    = sch_q;
   assign sample_valid = valid_q;
   assign error_active = err_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

   localparam int SETTLE = 2;
   localparam int DW     = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [5:0]    ch_mask;
   logic          error_req;
   logic [4:0]    mux_select;
   logic [DW-1:0] mux_data;
   logic [DW-1:0] sample_data;
   logic [2:0]    sample_ch;
   logic          sample_valid;
   logic          sample_ready;
   logic          busy;
   logic          error_active;

   logic [DW-1:0] mux_vals [0:6];

   int checks   = 0;
   int failures = 0;
   int exp_ptr  = 0;
   int cyc      = 0;

   mux_scan_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .DATA_W        (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .ch_mask      (ch_mask),
      .error_req    (error_req),
      .mux_select   (mux_select),
      .mux_data     (mux_data),
      .sample_data  (sample_data),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .error_active (error_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sensor mux: one fixed value per input, selected by the one-hot-ish code.
   always_comb begin
      case (mux_select)
         5'b00000: mux_data = mux_vals[0];
         5'b00001: mux_data = mux_vals[1];
         5'b00010: mux_data = mux_vals[2];
         5'b00100: mux_data = mux_vals[3];
         5'b01000: mux_data = mux_vals[4];
         5'b10000: mux_data = mux_vals[5];
         5'b11111: mux_data = mux_vals[6];
         default:  mux_data = 8'h00;
      endcase
   end

   // Reference: circular search for the first enabled channel starting at ptr.
   function automatic int next_ch(input logic [5:0] m, input int p);
      for (int k = 0; k < 6; k++) begin
         int c;
         c = (p + k) % 6;
         if (m[c]) return c;
      end
      return 0;
   endfunction

   function automatic logic [4:0] sel_code(input int c);
      if (c == 6) return 5'b11111;
      if (c == 0) return 5'b00000;
      return 5'(1 << (c - 1));
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Runs n channel samples against the reference scheduler; enable drops on the last one.
   task automatic run_burst(input int n, input bit rand_mode, input string tag);
      int t0, exp_c, w;
      for (int k = 0; k < n; k++) begin
         w = 0;
         while (busy !== 1'b1 && w < 30) begin tick(); w++; end
         t0    = cyc;
         exp_c = next_ch(ch_mask, exp_ptr);
         checks++;
         if (mux_select !== sel_code(exp_c)) begin
            failures++;
            $display("FAIL %s_select[%0d]: got %b, expected %b", tag, k, mux_select, sel_code(exp_c));
         end
         w = 0;
         while (sample_valid !== 1'b1 && w < 30) begin tick(); w++; end
         checks++;
         if (sample_valid !== 1'b1 || (cyc - t0) != SETTLE) begin
            failures++;
            $display("FAIL %s_latency[%0d]: valid=%b after %0d edges, expected 1 after %0d", tag, k, sample_valid, cyc - t0, SETTLE);
         end
         checks++;
         if (sample_ch !== 3'(exp_c)) begin
            failures++;
            $display("FAIL %s_ch[%0d]: got %0d, expected %0d", tag, k, sample_ch, exp_c);
         end
         checks++;
         if (sample_data !== mux_vals[exp_c]) begin
            failures++;
            $display("FAIL %s_data[%0d]: got %h, expected %h", tag, k, sample_data, mux_vals[exp_c]);
         end
         if (k == n - 1) enable = 1'b0;
         if (rand_mode && $urandom_range(0, 2) == 0) ch_mask = 6'($urandom_range(1, 63));
         w = 0;
         while (sample_valid === 1'b1 && w < 40) begin
            checks++;
            if (sample_ch !== 3'(exp_c) || sample_data !== mux_vals[exp_c] || mux_select !== sel_code(exp_c)) begin
               failures++;
               $display("FAIL %s_hold[%0d]: ch=%0d data=%h sel=%b, expected ch=%0d data=%h sel=%b", tag, k,
                        sample_ch, sample_data, mux_select, exp_c, mux_vals[exp_c], sel_code(exp_c));
            end
            sample_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            w++;
         end
         checks++;
         if (sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_handshake[%0d]: valid=%b, expected 0", tag, k, sample_valid);
         end
         exp_ptr = (exp_c + 1) % 6;
      end
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle: busy=%b, expected 0", tag, busy);
      end
      sample_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; ch_mask = 6'd0; error_req = 1'b0; sample_ready = 1'b0;
      for (int i = 0; i < 7; i++) mux_vals[i] = 8'(1 << i);
      tick(); tick(); tick();
      checks++;
      if (sample_valid !== 1'b0 || sample_data !== 8'h00 || sample_ch !== 3'd0 || busy !== 1'b0 ||
          error_active !== 1'b0 || mux_select !== 5'b00000) begin
         failures++;
         $display("FAIL reset_state: valid=%b data=%h ch=%0d busy=%b err=%b sel=%b, expected all zero",
                  sample_valid, sample_data, sample_ch, busy, error_active, mux_select);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: busy=%b, expected 0", busy);
      end
      exp_ptr = 0;
   endtask

   task automatic test_full_scan();
      ch_mask = 6'b111111; sample_ready = 1'b1; enable = 1'b1;
      run_burst(7, 1'b0, "full_scan");
   endtask

   task automatic test_two_channels();
      ch_mask = 6'b100100; sample_ready = 1'b1; enable = 1'b1;
      run_burst(4, 1'b0, "two_ch");
   endtask

   task automatic test_backpressure();
      int w;
      ch_mask = 6'b111111; sample_ready = 1'b1; enable = 1'b1;
      run_burst(1, 1'b0, "bp_ch0");
      enable = 1'b1; sample_ready = 1'b0;
      w = 0;
      while (sample_valid !== 1'b1 && w < 30) begin tick(); w++; end
      checks++;
      if (sample_valid !== 1'b1 || sample_ch !== 3'd1 || sample_data !== 8'h02) begin
         failures++;
         $display("FAIL bp_ch1_sample: valid=%b ch=%0d data=%h, expected 1 1 02", sample_valid, sample_ch, sample_data);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (sample_valid !== 1'b1 || sample_data !== 8'h02 || mux_select !== 5'b00001) begin
            failures++;
            $display("FAIL bp_stall[%0d]: valid=%b data=%h sel=%b, expected 1 02 00001", i, sample_valid, sample_data, mux_select);
         end
      end
      sample_ready = 1'b1;
      tick();
      checks++;
      if (sample_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: valid=%b, expected 0", sample_valid);
      end
      exp_ptr = 2;
      run_burst(1, 1'b0, "bp_next");
   endtask

   task automatic test_error_preempt();
      int t0, w;
      ch_mask = 6'b111111; sample_ready = 1'b1; enable = 1'b1;
      w = 0;
      while (busy !== 1'b1 && w < 30) begin tick(); w++; end
      checks++;
      if (mux_select !== 5'b00100) begin
         failures++;
         $display("FAIL err_pre_select: got %b, expected 00100", mux_select);
      end
      error_req = 1'b1;
      tick();
      error_req = 1'b0;
      t0 = cyc;
      checks++;
      if (mux_select !== 5'b11111 || error_active !== 1'b1) begin
         failures++;
         $display("FAIL err_enter: sel=%b err=%b, expected 11111 1", mux_select, error_active);
      end
      w = 0;
      while (sample_valid !== 1'b1 && w < 30) begin tick(); w++; end
      checks++;
      if (sample_valid !== 1'b1 || (cyc - t0) != SETTLE) begin
         failures++;
         $display("FAIL err_latency: valid=%b after %0d edges, expected 1 after %0d", sample_valid, cyc - t0, SETTLE);
      end
      checks++;
      if (sample_ch !== 3'd6 || sample_data !== 8'h40 || error_active !== 1'b1) begin
         failures++;
         $display("FAIL err_sample: ch=%0d data=%h err=%b, expected 6 40 1", sample_ch, sample_data, error_active);
      end
      tick();
      checks++;
      if (sample_valid !== 1'b0 || error_active !== 1'b0) begin
         failures++;
         $display("FAIL err_done: valid=%b err=%b, expected 0 0", sample_valid, error_active);
      end
      run_burst(1, 1'b0, "err_resume");
   endtask

   task automatic test_reset_in_hold();
      int w;
      ch_mask = 6'b111111; sample_ready = 1'b0; enable = 1'b1;
      w = 0;
      while (sample_valid !== 1'b1 && w < 30) begin tick(); w++; end
      checks++;
      if (sample_valid !== 1'b1 || sample_ch !== 3'd4) begin
         failures++;
         $display("FAIL rst_hold_pre: valid=%b ch=%0d, expected 1 4", sample_valid, sample_ch);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (sample_valid !== 1'b0 || sample_data !== 8'h00 || busy !== 1'b0 || mux_select !== 5'b00000 ||
          sample_ch !== 3'd0 || error_active !== 1'b0) begin
         failures++;
         $display("FAIL rst_hold: valid=%b data=%h busy=%b sel=%b ch=%0d err=%b, expected all zero",
                  sample_valid, sample_data, busy, mux_select, sample_ch, error_active);
      end
      rst = 1'b0; sample_ready = 1'b1;
      exp_ptr = 0;
      run_burst(1, 1'b0, "post_rst");
   endtask

   task automatic test_empty_mask();
      ch_mask = 6'b000000; enable = 1'b1; sample_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_mask[%0d]: busy=%b valid=%b, expected 0 0", i, busy, sample_valid);
         end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 7; i++) mux_vals[i] = 8'($urandom_range(0, 255));
         ch_mask = 6'($urandom_range(1, 63));
         enable  = 1'b1;
         run_burst(int'($urandom_range(3, 8)), 1'b1, "random");
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_scan();
      test_two_channels();
      test_backpressure();
      test_error_preempt();
      test_reset_in_hold();
      test_empty_mask();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
